tap_prog_streamer: RTL and testbench

// Initiator side of the tap-programming handshake (tap_din/valid/ready/done) used by tiny_fir, reverb and the IIR tap ports.

---
 rtl/tap_prog_streamer.sv | 184 ++++++++++++++++++
 tb/tb_tap_prog_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_prog_streamer.sv
// tap_prog_streamer
// Loads coefficients from a local RAM and streams them over the
// tap_din / valid / ready / done handshake to a filter, index 0 first,
// then waits for the filter's done level and reports success or timeout.
module tap_prog_streamer #(
    parameter int G_NUM_TAPS     = 129,
    parameter int G_TAP_WIDTH    = 16,
    parameter int G_AWIDTH       = 8,
    parameter int G_DONE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [G_AWIDTH-1:0]    wr_addr,
    input  logic [G_TAP_WIDTH-1:0] wr_data,
    input  logic                   wr_en,
    input  logic                   start,
    output logic [G_TAP_WIDTH-1:0] tap_dout,
    output logic                   tap_dout_valid,
    input  logic                   tap_dout_ready,
    input  logic                   tap_done,
    output logic                   busy,
    output logic                   prog_done,
    output logic                   prog_error,
    output logic                   wr_reject
);

    // Counter is one bit wider than needed so a timeout of 1 still has a legal width.
    localparam int CNT_W = $clog2(G_DONE_TIMEOUT) + 1;
    localparam int DEPTH = 2 ** G_AWIDTH;

    localparam logic [G_AWIDTH-1:0] LAST_IDX = G_AWIDTH'(G_NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(G_DONE_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FETCH     = 2'd1;
    localparam logic [1:0] S_SEND      = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // Coefficient storage; never cleared so software contents survive resets.
    logic [G_TAP_WIDTH-1:0] mem [0:DEPTH-1];
    logic [G_TAP_WIDTH-1:0] rd_data_reg;
    logic                   rd_en;
    logic [G_AWIDTH-1:0]    rd_addr;

    logic [1:0]             state_reg,      state_next;
    logic [G_AWIDTH-1:0]    idx_reg,        idx_next;
    logic [CNT_W-1:0]       cnt_reg,        cnt_next;
    logic [G_TAP_WIDTH-1:0] tap_dout_reg,   tap_dout_next;
    logic                   valid_reg,      valid_next;
    logic                   busy_reg,       busy_next;
    logic                   prog_done_reg,  prog_done_next;
    logic                   prog_error_reg, prog_error_next;
    logic                   wr_reject_reg,  wr_reject_next;

    // Soft reset from enable behaves identically to the hard reset.
    logic clear;
    assign clear = reset | ~enable;

    // RAM write port: software writes land only while no run is active.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_reg) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // RAM read port: one-cycle registered read issued by the FSM.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    // Next-state logic for the streaming FSM, status flags and counters.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        tap_dout_next   = tap_dout_reg;
        valid_next      = valid_reg;
        busy_next       = busy_reg;
        prog_done_next  = prog_done_reg;
        prog_error_next = prog_error_reg;
        wr_reject_next  = wr_reject_reg;
        rd_en           = 1'b0;
        rd_addr         = '0;

        // A write arriving mid-run is dropped by the RAM port; remember that it happened.
        if (wr_en && busy_reg) begin
            wr_reject_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                // start is only honoured here; the RAM read of entry 0 begins immediately.
                if (start) begin
                    state_next      = S_FETCH;
                    busy_next       = 1'b1;
                    prog_done_next  = 1'b0;
                    prog_error_next = 1'b0;
                    wr_reject_next  = 1'b0;
                    idx_next        = '0;
                    rd_en           = 1'b1;
                    rd_addr         = '0;
                end
            end

            S_FETCH: begin
                // Read data is available now; present it to the filter.
                tap_dout_next = rd_data_reg;
                valid_next    = 1'b1;
                state_next    = S_SEND;
            end

            S_SEND: begin
                // Hold data and valid until the filter accepts the tap.
                if (tap_dout_ready) begin
                    valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = S_WAIT_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        rd_en      = 1'b1;
                        rd_addr    = idx_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end

            S_WAIT_DONE: begin
                // done wins over a timeout landing in the same cycle.
                if (tap_done) begin
                    prog_done_next = 1'b1;
                    busy_next      = 1'b0;
                    state_next     = S_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    prog_error_next = 1'b1;
                    busy_next       = 1'b0;
                    state_next      = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset or enable low aborts any run.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            tap_dout_reg   <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            prog_done_reg  <= 1'b0;
            prog_error_reg <= 1'b0;
            wr_reject_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            tap_dout_reg   <= tap_dout_next;
            valid_reg      <= valid_next;
            busy_reg       <= busy_next;
            prog_done_reg  <= prog_done_next;
            prog_error_reg <= prog_error_next;
            wr_reject_reg  <= wr_reject_next;
        end
    end

    assign tap_dout       = tap_dout_reg;
    assign tap_dout_valid = valid_reg;
    assign busy           = busy_reg;
    assign prog_done      = prog_done_reg;
    assign prog_error     = prog_error_reg;
    assign wr_reject      = wr_reject_reg;

endmodule

// File: tb/tb_tap_prog_streamer.sv
// Directed testbench for tap_prog_streamer: streams, backpressure,
// timeout, rejected writes, soft reset and ignored start pulses.
module tb_tap_prog_streamer;

    localparam int NUM = 129;
    localparam int TMO = 1024;
    localparam int AW  = 8;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] tap_dout;
    logic          tap_dout_valid;
    logic          tap_dout_ready = 1'b0;
    logic          tap_done = 1'b0;
    logic          busy;
    logic          prog_done;
    logic          prog_error;
    logic          wr_reject;

    int checks = 0;
    int passed = 0;

    logic [TW-1:0] exp_mem [0:255];
    logic [TW-1:0] got_q [$];
    int first_valid_cyc;
    int last_hs_cyc;
    int end_cyc;
    int stab_viol;
    logic busy_at1;

    tap_prog_streamer #(
        .G_NUM_TAPS(NUM), .G_TAP_WIDTH(TW), .G_AWIDTH(AW), .G_DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .start(start),
        .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
        .tap_dout_ready(tap_dout_ready), .tap_done(tap_done),
        .busy(busy), .prog_done(prog_done), .prog_error(prog_error),
        .wr_reject(wr_reject)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [TW-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        exp_mem[a] = d;
    endtask

    // Drives one run. done_mode: >=0 delay after last handshake, -1 never, -2 high before start.
    task automatic run_stream(input int bp, input int done_mode, input bit poke_start, input bit poke_write);
        int cyc;
        logic rdy;
        logic prev_stall;
        logic [TW-1:0] prev_dout;
        got_q.delete();
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        end_cyc = -1;
        stab_viol = 0;
        prev_stall = 1'b0;
        prev_dout = '0;
        tap_done = (done_mode == -2);
        start = 1'b1;
        step();
        start = 1'b0;
        busy_at1 = busy;
        cyc = 1;
        for (int guard = 0; guard < 5000; guard++) begin
            if (!busy && cyc > 1) begin
                end_cyc = cyc;
                break;
            end
            if (prev_stall && (!tap_dout_valid || tap_dout !== prev_dout)) stab_viol++;
            if (tap_dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            rdy = (bp == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp);
            tap_dout_ready = rdy;
            start = poke_start && (cyc % 7 == 3);
            wr_en = poke_write && (cyc == 10);
            wr_addr = 8'd5;
            wr_data = 16'hDEAD;
            if (tap_dout_valid && rdy) begin
                got_q.push_back(tap_dout);
                if (got_q.size() == NUM) last_hs_cyc = cyc;
            end
            prev_stall = tap_dout_valid && !rdy;
            prev_dout = tap_dout;
            if (done_mode >= 0 && last_hs_cyc >= 0 && cyc >= last_hs_cyc + done_mode) tap_done = 1'b1;
            step();
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        tap_dout_ready = 1'b0;
        tap_done = 1'b0;
        $display("run: taps=%0d first_valid=%0d last_hs=%0d end=%0d done=%0b err=%0b rej=%0b",
                 got_q.size(), first_valid_cyc, last_hs_cyc, end_cyc, prog_done, prog_error, wr_reject);
    endtask

    // Sequence comparison is written out in each test that needs it.
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (tap_dout !== 16'h0) $display("FAIL reset_dout got=%h exp=0000", tap_dout); else passed++;
        checks++; if (tap_dout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", tap_dout_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (prog_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", prog_done); else passed++;
        checks++; if (prog_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", prog_error); else passed++;
        checks++; if (wr_reject !== 1'b0) $display("FAIL reset_reject got=%b exp=0", wr_reject); else passed++;
        reset = 1'b0;
        step();
        for (int i = 0; i < NUM; i++) write_word(AW'(i), 16'h0100 + TW'(i));
        write_word(8'd200, 16'hBEEF);
        write_word(8'd129, 16'hCAFE);
    endtask

    task automatic test_stream();
        int bad;
        run_stream(0, 3, 1'b0, 1'b0);
        bad = -1;
        for (int i = 0; i < NUM && i < got_q.size(); i++) if (got_q[i] !== exp_mem[i] && bad < 0) bad = i;
        checks++; if (busy_at1 !== 1'b1) $display("FAIL stream_busy_at1 got=%b exp=1", busy_at1); else passed++;
        checks++; if (first_valid_cyc != 2) $display("FAIL stream_first_valid got=%0d exp=2", first_valid_cyc); else passed++;
        checks++; if (got_q.size() != NUM) $display("FAIL stream_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (bad >= 0) $display("FAIL stream_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_mem[bad]); else passed++;
        checks++; if (last_hs_cyc != 258) $display("FAIL stream_last_hs got=%0d exp=258", last_hs_cyc); else passed++;
        checks++; if (end_cyc != 262) $display("FAIL stream_end got=%0d exp=262", end_cyc); else passed++;
        checks++; if (prog_done !== 1'b1) $display("FAIL stream_done got=%b exp=1", prog_done); else passed++;
        checks++; if (prog_error !== 1'b0) $display("FAIL stream_error got=%b exp=0", prog_error); else passed++;
        checks++; if (tap_dout_valid !== 1'b0) $display("FAIL stream_valid_after got=%b exp=0", tap_dout_valid); else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        run_stream(50, 2, 1'b0, 1'b0);
        bad = -1;
        for (int i = 0; i < NUM && i < got_q.size(); i++) if (got_q[i] !== exp_mem[i] && bad < 0) bad = i;
        checks++; if (got_q.size() != NUM) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (bad >= 0) $display("FAIL bp_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_mem[bad]); else passed++;
        checks++; if (stab_viol != 0) $display("FAIL bp_stable violations=%0d exp=0", stab_viol); else passed++;
        checks++; if (end_cyc != last_hs_cyc + 3) $display("FAIL bp_end got=%0d exp=%0d", end_cyc, last_hs_cyc + 3); else passed++;
        checks++; if (prog_done !== 1'b1) $display("FAIL bp_done got=%b exp=1", prog_done); else passed++;
    endtask

    task automatic test_done_early();
        run_stream(0, -2, 1'b0, 1'b0);
        checks++; if (got_q.size() != NUM) $display("FAIL early_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (end_cyc != last_hs_cyc + 2) $display("FAIL early_end got=%0d exp=%0d", end_cyc, last_hs_cyc + 2); else passed++;
        checks++; if (prog_done !== 1'b1) $display("FAIL early_done got=%b exp=1", prog_done); else passed++;
    endtask

    task automatic test_timeout();
        run_stream(0, -1, 1'b0, 1'b0);
        checks++; if (got_q.size() != NUM) $display("FAIL tmo_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (end_cyc != last_hs_cyc + 1 + TMO) $display("FAIL tmo_end got=%0d exp=%0d", end_cyc, last_hs_cyc + 1 + TMO); else passed++;
        checks++; if (prog_error !== 1'b1) $display("FAIL tmo_error got=%b exp=1", prog_error); else passed++;
        checks++; if (prog_done !== 1'b0) $display("FAIL tmo_done got=%b exp=0", prog_done); else passed++;
    endtask

    task automatic test_wr_reject();
        int bad;
        run_stream(0, 1, 1'b0, 1'b1);
        checks++; if (wr_reject !== 1'b1) $display("FAIL rej_flag got=%b exp=1", wr_reject); else passed++;
        run_stream(0, 1, 1'b0, 1'b0);
        bad = -1;
        for (int i = 0; i < NUM && i < got_q.size(); i++) if (got_q[i] !== exp_mem[i] && bad < 0) bad = i;
        checks++; if (got_q.size() < 6 || got_q[5] !== 16'h0105) $display("FAIL rej_ram5 got=%h exp=0105", (got_q.size() > 5) ? got_q[5] : 16'hxxxx); else passed++;
        checks++; if (bad >= 0) $display("FAIL rej_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_mem[bad]); else passed++;
        checks++; if (wr_reject !== 1'b0) $display("FAIL rej_cleared got=%b exp=0", wr_reject); else passed++;
    endtask

    task automatic test_soft_reset();
        int hs;
        int guard;
        int bad;
        start = 1'b1;
        step();
        start = 1'b0;
        tap_dout_ready = 1'b1;
        wr_addr = 8'd5;
        wr_data = 16'hDEAD;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        hs = 0;
        guard = 0;
        while (!(tap_dout_valid && hs == 40) && guard < 1000) begin
            if (tap_dout_valid) hs++;
            step();
            guard++;
        end
        checks++; if (guard >= 1000) $display("FAIL soft_reach40 got=timeout exp=idx40"); else passed++;
        checks++; if (tap_dout !== exp_mem[40]) $display("FAIL soft_idx40 got=%h exp=%h", tap_dout, exp_mem[40]); else passed++;
        checks++; if (wr_reject !== 1'b1) $display("FAIL soft_rej_pre got=%b exp=1", wr_reject); else passed++;
        enable = 1'b0;
        tap_dout_ready = 1'b0;
        step();
        checks++; if (tap_dout_valid !== 1'b0) $display("FAIL soft_valid got=%b exp=0", tap_dout_valid); else passed++;
        checks++; if (tap_dout !== 16'h0) $display("FAIL soft_dout got=%h exp=0000", tap_dout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL soft_busy got=%b exp=0", busy); else passed++;
        checks++; if ({prog_done, prog_error, wr_reject} !== 3'b000) $display("FAIL soft_flags got=%b exp=000", {prog_done, prog_error, wr_reject}); else passed++;
        enable = 1'b1;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL soft_idle got=%b exp=0", busy); else passed++;
        run_stream(0, 2, 1'b0, 1'b0);
        bad = -1;
        for (int i = 0; i < NUM && i < got_q.size(); i++) if (got_q[i] !== exp_mem[i] && bad < 0) bad = i;
        checks++; if (got_q.size() != NUM) $display("FAIL soft_restream_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (bad >= 0) $display("FAIL soft_restream_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_mem[bad]); else passed++;
    endtask

    task automatic test_start_ignored();
        int bad;
        run_stream(30, 4, 1'b1, 1'b0);
        bad = -1;
        for (int i = 0; i < NUM && i < got_q.size(); i++) if (got_q[i] !== exp_mem[i] && bad < 0) bad = i;
        checks++; if (got_q.size() != NUM) $display("FAIL ign_count got=%0d exp=%0d", got_q.size(), NUM); else passed++;
        checks++; if (bad >= 0) $display("FAIL ign_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_mem[bad]); else passed++;
        checks++; if (prog_done !== 1'b1) $display("FAIL ign_done got=%b exp=1", prog_done); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL ign_idle_after got=%b exp=0", busy); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_done_early();
        test_timeout();
        test_wr_reject();
        test_soft_reset();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
